sync_fifo_ctrl: RTL

Parametrised single-clock FIFO for producer/consumer paths that share one clock domain. Successor to the team's dual-clock FIFO: no pointer synchronisers, but it adds explicit write/read enables, an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags and a selectable first-word-fall-through (FWFT) read mode. Storage is a simple dual-port register array in a sub-module.

---
 rtl/sync_fifo_ctrl_pkg.sv | 34 +++
 rtl/fifo_mem.sv | 34 +++
 rtl/sync_fifo_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared sizing helpers and defaults for the single- and dual-clock FIFO family.
// Depth and counter widths are derived here so every FIFO agrees on them.
package sync_fifo_ctrl_pkg;

    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_POINTER = 4;

    // Which of the two ports actually moved a word this cycle.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

    function automatic int fifo_depth(input int pointer);
        return 1 << pointer;
    endfunction

    function automatic int fifo_clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Occupancy has to represent 0..DEPTH inclusive.
    function automatic int count_width(input int pointer);
        return fifo_clog2(fifo_depth(pointer) + 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
// Holds data only; all bookkeeping lives in the controller.
module fifo_mem
    import sync_fifo_ctrl_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int POINTER = DEFAULT_POINTER
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [POINTER-1:0] wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [POINTER-1:0] rd_addr,
    output logic [WIDTH-1:0]   rd_data
);

    localparam int DEPTH = fifo_depth(POINTER);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; stale words are unreachable because the
    // controller's pointers and count are reset, and a reset here would turn
    // the array into a much larger flop-with-reset structure for no benefit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            // NOTE: non-blocking so the array updates after every reader of
            // this edge has seen the old contents.
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy count, threshold flags,
// sticky error flags and a registered or first-word-fall-through read port.
module sync_fifo_ctrl
    import sync_fifo_ctrl_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int POINTER    = DEFAULT_POINTER,
    parameter int AFULL_LVL  = fifo_depth(POINTER) - 2,
    parameter int AEMPTY_LVL = 1,
    parameter bit FWFT       = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [WIDTH-1:0]   data_in,
    input  logic               rd_en,
    output logic [WIDTH-1:0]   data_out,
    output logic               rd_valid,
    output logic               wr_full,
    output logic               rd_empty,
    output logic               almost_full,
    output logic               almost_empty,
    output logic [POINTER:0]   count,
    output logic               overflow,
    output logic               underflow
);

    localparam int DEPTH = fifo_depth(POINTER);
    localparam int CNT_W = count_width(POINTER);

    localparam logic [CNT_W-1:0]   DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]   AFULL_C  = CNT_W'(AFULL_LVL);
    localparam logic [CNT_W-1:0]   AEMPTY_C = CNT_W'(AEMPTY_LVL);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [POINTER:0]   PTR_ONE  = (POINTER + 1)'(1);

    logic [POINTER:0] wr_ptr_q, wr_ptr_d;
    logic [POINTER:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] dout_q, dout_d;

    logic             full;
    logic             empty;
    logic             wr_acc;
    logic             rd_acc;
    fifo_op_e         op;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_we;

    // Acceptance is judged against the registered count only, so a full FIFO
    // never passes a write through even when a read frees a slot this cycle.
    always_comb begin
        full   = (count_q == DEPTH_C);
        empty  = (count_q == '0);
        wr_acc = wr_en & ~full;
        rd_acc = rd_en & ~empty;
        op     = fifo_op_e'({wr_acc, rd_acc});
        mem_we = wr_acc & ~reset;
    end

    always_comb begin
        // NOTE: every next-state variable takes its hold value first, so no
        // path through the block leaves one unassigned and infers a latch.
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        rd_valid_d  = 1'b0;
        dout_d      = dout_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            rd_valid_d = 1'b1;
            dout_d     = mem_rdata;
        end

        case (op)
            OP_WRITE: count_d = count_q + CNT_ONE;
            OP_READ:  count_d = count_q - CNT_ONE;
            default:  count_d = count_q;
        endcase

        if (wr_en && full) begin
            overflow_d = 1'b1;
        end
        if (rd_en && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            dout_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            rd_valid_q  <= rd_valid_d;
            dout_q      <= dout_d;
        end
    end

    // The extra pointer bit exists so the pointer distance always equals count.
    always @(posedge clk) begin
        if (!reset) begin
            assert ((wr_ptr_q - rd_ptr_q) == count_q);
        end
    end

    fifo_mem #(
        .WIDTH   (WIDTH),
        .POINTER (POINTER)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (wr_ptr_q[POINTER-1:0]),
        .wr_data (data_in),
        .rd_addr (rd_ptr_q[POINTER-1:0]),
        .rd_data (mem_rdata)
    );

    assign wr_full      = full;
    assign rd_empty     = empty;
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    if (FWFT) begin : g_fwft
        assign data_out = mem_rdata;
        assign rd_valid = ~empty;
    end else begin : g_registered
        assign data_out = dout_q;
        assign rd_valid = rd_valid_q;
    end

endmodule
